free_list: RTL and testbench

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list.sv | 103 ++++++++++
 tb/tb_free_list.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Physical-register free list: a circular buffer of tags handed out to dispatch slots
// and refilled by retiring Told tags, with head rollback on a retirement-time mispredict.
module free_list #(
  parameter int N_WAY    = 2,
  parameter int CDB_BITS = 6,
  parameter int XLEN     = 32,
  parameter int N_PR     = 64
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [N_WAY-1:0]                   dis_req,
  output logic [N_WAY-1:0][CDB_BITS-1:0]     pr_freelist,
  input  logic [N_WAY-1:0]                   rt_valid,
  input  logic [N_WAY-1:0][CDB_BITS-1:0]     rt_told,
  input  logic                               branch_haz,
  output logic [CDB_BITS-1:0]                free_count,
  output logic                               dis_stall
);

  localparam int DEPTH = N_PR - 1 - XLEN;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CDB_BITS-1:0]          entry_q [DEPTH];
  logic [PTR_W-1:0]             head_q, tail_q, rhead_q;
  logic [PTR_W-1:0]             head_d, tail_d, rhead_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [N_WAY-1:0][CDB_BITS-1:0] offer;
  logic [N_WAY-1:0]             push_en;
  logic [N_WAY-1:0][PTR_W-1:0]  push_idx;
  int                           grant_c, pushed_c, count_sum;

  // Offsets never exceed N_WAY <= DEPTH, so one conditional subtract is a full modulo.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    int rank;
    rank = 0;
    for (int w = 0; w < N_WAY; w++) begin
      offer[w] = '0;
      if (dis_req[w]) begin
        if (rank < int'(count_q)) offer[w] = entry_q[wrap_add(head_q, rank)];
        rank = rank + 1;
      end
    end
    grant_c = branch_haz ? 0 : ((rank < int'(count_q)) ? rank : int'(count_q));

    pushed_c = 0;
    for (int w = 0; w < N_WAY; w++) begin
      push_en[w]  = rt_valid[w] && (rt_told[w] > CDB_BITS'(1));
      push_idx[w] = wrap_add(tail_q, pushed_c);
      if (push_en[w]) pushed_c = pushed_c + 1;
    end

    tail_d    = wrap_add(tail_q, pushed_c);
    rhead_d   = wrap_add(rhead_q, pushed_c);
    count_sum = int'(count_q) - grant_c + pushed_c;
    if (branch_haz) begin
      head_d  = rhead_d;
      count_d = CNT_W'(DEPTH);
    end else begin
      head_d  = wrap_add(head_q, grant_c);
      count_d = CNT_W'(count_sum);
    end
  end

  // NOTE: the tag store is reset like any other register because its reset contents are the free tags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= CDB_BITS'(XLEN + 1 + i);
      head_q  <= '0;
      tail_q  <= '0;
      rhead_q <= '0;
      count_q <= CNT_W'(DEPTH);
    end else begin
      for (int w = 0; w < N_WAY; w++) begin
        if (push_en[w]) entry_q[push_idx[w]] <= rt_told[w];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      rhead_q <= rhead_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    pr_freelist = reset ? offer : '0;
    free_count  = CDB_BITS'(count_q);
    dis_stall   = int'(count_q) < N_WAY;
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    branch_haz || (count_sum <= DEPTH));
`endif

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed corner cases plus a randomized run against a
// behavioural model built on absolute allocation/free sequence numbers.
module tb_free_list;

  localparam int N_WAY    = 2;
  localparam int CDB_BITS = 6;
  localparam int XLEN     = 32;
  localparam int N_PR     = 64;
  localparam int DEPTH    = N_PR - 1 - XLEN;

  logic                           clock = 1'b0;
  logic                           reset = 1'b0;
  logic [N_WAY-1:0]               dis_req = '0;
  logic [N_WAY-1:0][CDB_BITS-1:0] pr_freelist;
  logic [N_WAY-1:0]               rt_valid = '0;
  logic [N_WAY-1:0][CDB_BITS-1:0] rt_told = '0;
  logic                           branch_haz = 1'b0;
  logic [CDB_BITS-1:0]            free_count;
  logic                           dis_stall;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: tag slots addressed by absolute sequence numbers modulo DEPTH.
  int m_mem [DEPTH];
  int m_alloc_abs;
  int m_push_abs;
  int m_count;

  always #5 clock = ~clock;

  free_list #(.N_WAY(N_WAY), .CDB_BITS(CDB_BITS), .XLEN(XLEN), .N_PR(N_PR)) dut (
    .clock      (clock),
    .reset      (reset),
    .dis_req    (dis_req),
    .pr_freelist(pr_freelist),
    .rt_valid   (rt_valid),
    .rt_told    (rt_told),
    .branch_haz (branch_haz),
    .free_count (free_count),
    .dis_stall  (dis_stall)
  );

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = XLEN + 1 + i;
    m_alloc_abs = 0;
    m_push_abs  = 0;
    m_count     = DEPTH;
  endtask

  function automatic int exp_tag(input int w);
    int r;
    r = 0;
    if (!dis_req[w]) return 0;
    for (int k = 0; k < w; k++) if (dis_req[k]) r++;
    if (r >= m_count) return 0;
    return m_mem[(m_alloc_abs + r) % DEPTH];
  endfunction

  function automatic int n_pushes(input logic [1:0] rv, input logic [5:0] t1, input logic [5:0] t0);
    int p;
    p = 0;
    if (rv[0] && t0 > 6'd1) p++;
    if (rv[1] && t1 > 6'd1) p++;
    return p;
  endfunction

  task automatic drive(input logic [1:0] req, input logic [1:0] rv,
                       input logic [5:0] t1, input logic [5:0] t0, input logic bh);
    dis_req    = req;
    rt_valid   = rv;
    rt_told[1] = t1;
    rt_told[0] = t0;
    branch_haz = bh;
  endtask

  // Apply the current inputs to the model, then let the DUT see one rising edge.
  task automatic tick();
    int want, g, p;
    want = $countones(dis_req);
    g    = branch_haz ? 0 : ((want < m_count) ? want : m_count);
    p    = 0;
    for (int w = 0; w < N_WAY; w++) begin
      if (rt_valid[w] && rt_told[w] > 6'd1) begin
        m_mem[m_push_abs % DEPTH] = int'(rt_told[w]);
        m_push_abs++;
        p++;
      end
    end
    if (branch_haz) begin
      m_alloc_abs = m_push_abs;
      m_count     = DEPTH;
    end else begin
      m_alloc_abs += g;
      m_count     = m_count - g + p;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    drive(2'b11, 2'b11, 6'd9, 6'd5, 1'b0);
    repeat (2) @(negedge clock);
    tests_run++;
    if (pr_freelist !== '0) begin
      tests_failed++; $display("FAIL reset_pr: got %h want 0", pr_freelist);
    end
    tests_run++;
    if (free_count !== 6'd31) begin
      tests_failed++; $display("FAIL reset_count: got %0d want 31", free_count);
    end
    tests_run++;
    if (dis_stall !== 1'b0) begin
      tests_failed++; $display("FAIL reset_stall: got %b want 0", dis_stall);
    end
    do_reset();
  endtask

  task automatic test_dual_alloc();
    do_reset();
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    tests_run++;
    if (pr_freelist[0] !== 6'd33 || pr_freelist[1] !== 6'd34) begin
      tests_failed++; $display("FAIL dual_alloc_tags: got {%0d,%0d} want {34,33}", pr_freelist[1], pr_freelist[0]);
    end
    tests_run++;
    if (free_count !== 6'd31) begin
      tests_failed++; $display("FAIL dual_alloc_count0: got %0d want 31", free_count);
    end
    tick();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    tests_run++;
    if (free_count !== 6'd29) begin
      tests_failed++; $display("FAIL dual_alloc_count1: got %0d want 29", free_count);
    end
    tick();
  endtask

  task automatic test_split_alloc();
    do_reset();
    drive(2'b10, 2'b00, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    tests_run++;
    if (pr_freelist[1] !== 6'd33 || pr_freelist[0] !== 6'd0) begin
      tests_failed++; $display("FAIL split_alloc_a: got {%0d,%0d} want {33,0}", pr_freelist[1], pr_freelist[0]);
    end
    tick();
    drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    tests_run++;
    if (pr_freelist[0] !== 6'd34 || pr_freelist[1] !== 6'd0) begin
      tests_failed++; $display("FAIL split_alloc_b: got {%0d,%0d} want {0,34}", pr_freelist[1], pr_freelist[0]);
    end
    tick();
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
      tick();
    end
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    tests_run++;
    if (pr_freelist[0] !== 6'd63 || pr_freelist[1] !== 6'd0) begin
      tests_failed++; $display("FAIL drain_last: got {%0d,%0d} want {0,63}", pr_freelist[1], pr_freelist[0]);
    end
    tests_run++;
    if (dis_stall !== 1'b1 || free_count !== 6'd1) begin
      tests_failed++; $display("FAIL drain_stall: got stall=%b count=%0d want stall=1 count=1", dis_stall, free_count);
    end
    tick();
    @(negedge clock);
    tests_run++;
    if (pr_freelist !== '0 || free_count !== 6'd0) begin
      tests_failed++; $display("FAIL drain_empty: got pr=%h count=%0d want pr=0 count=0", pr_freelist, free_count);
    end
    tick();
  endtask

  task automatic test_retire_filter();
    do_reset();
    drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    drive(2'b00, 2'b11, 6'd1, 6'd5, 1'b0);
    @(negedge clock);
    tests_run++;
    if (free_count !== 6'd30) begin
      tests_failed++; $display("FAIL retire_pre: got %0d want 30", free_count);
    end
    tick();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    tests_run++;
    if (free_count !== 6'd31) begin
      tests_failed++; $display("FAIL retire_post: got %0d want 31", free_count);
    end
    for (int i = 0; i < 15; i++) begin
      drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
      tick();
    end
    drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    tests_run++;
    if (pr_freelist[0] !== 6'd5) begin
      tests_failed++; $display("FAIL retire_wrap: got %0d want 5", pr_freelist[0]);
    end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    drive(2'b11, 2'b01, 6'd0, 6'd7, 1'b1);
    @(negedge clock);
    tests_run++;
    if (free_count !== 6'd28) begin
      tests_failed++; $display("FAIL branch_pre: got %0d want 28", free_count);
    end
    tick();
    drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    tests_run++;
    if (free_count !== 6'd31 || pr_freelist[0] !== 6'd34) begin
      tests_failed++; $display("FAIL branch_post: got count=%0d tag=%0d want count=31 tag=34", free_count, pr_freelist[0]);
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
      tick();
    end
    drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
    tick();
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    tests_run++;
    if (free_count !== 6'd10) begin
      tests_failed++; $display("FAIL async_pre: got %0d want 10", free_count);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (free_count !== 6'd31 || pr_freelist !== '0 || dis_stall !== 1'b0) begin
      tests_failed++; $display("FAIL async_reset: got count=%0d pr=%h stall=%b want 31/0/0", free_count, pr_freelist, dis_stall);
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [1:0] req, rv;
      logic [5:0] t0, t1;
      logic       bh;
      int         want, g;
      req  = 2'($urandom);
      rv   = (c < 250 && $urandom_range(3) != 0) ? 2'b00 : 2'($urandom);
      t0   = 6'($urandom);
      t1   = 6'($urandom);
      bh   = ($urandom_range(19) == 0);
      want = $countones(req);
      g    = bh ? 0 : ((want < m_count) ? want : m_count);
      for (int w = 1; w >= 0; w--) begin
        if (!bh && (m_count - g + n_pushes(rv, t1, t0) > DEPTH)) rv[w] = 1'b0;
      end
      drive(req, rv, t1, t0, bh);
      @(negedge clock);
      for (int w = 0; w < N_WAY; w++) begin
        tests_run++;
        if (pr_freelist[w] !== 6'(exp_tag(w))) begin
          tests_failed++; $display("FAIL rand_tag[%0d] cyc %0d: got %0d want %0d", w, c, pr_freelist[w], exp_tag(w));
        end
      end
      tests_run++;
      if (free_count !== 6'(m_count)) begin
        tests_failed++; $display("FAIL rand_count cyc %0d: got %0d want %0d", c, free_count, m_count);
      end
      tests_run++;
      if (dis_stall !== (m_count < N_WAY)) begin
        tests_failed++; $display("FAIL rand_stall cyc %0d: got %b want %b", c, dis_stall, m_count < N_WAY);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_dual_alloc();
    test_split_alloc();
    test_drain();
    test_retire_filter();
    test_branch();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
